// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the alarm sequencer and its surroundings: time compare,
// debounced buttons, buzzer enable and status outputs.
interface alarm_sequencer_if;
    logic       alarm_en;
    logic       time_match;
    logic       snooze_btn;
    logic       stop_btn;
    logic       buzzer_en;
    logic [1:0] state;
    logic [3:0] snooze_cnt;
    logic       missed;

    modport master (
        output alarm_en, time_match, snooze_btn, stop_btn,
        input  buzzer_en, state, snooze_cnt, missed
    );

    modport slave (
        input  alarm_en, time_match, snooze_btn, stop_btn,
        output buzzer_en, state, snooze_cnt, missed
    );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm-clock controller: rings on a time_match rising edge, beeps the buzzer in an
// ON/OFF tick pattern, and handles snooze, stop and unanswered-ring timeout.
module alarm_sequencer #(
    parameter int unsigned TICK_DIV     = 100000000,
    parameter int unsigned ON_TICKS     = 1,
    parameter int unsigned OFF_TICKS    = 1,
    parameter int unsigned RING_TIMEOUT = 60,
    parameter int unsigned SNOOZE_TICKS = 300,
    parameter int unsigned MAX_SNOOZE   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    alarm_sequencer_if.slave   bus
);

    localparam int unsigned TickMax = (RING_TIMEOUT > SNOOZE_TICKS) ? RING_TIMEOUT : SNOOZE_TICKS;
    localparam int unsigned PreW    = $clog2(TICK_DIV + 1);
    localparam int unsigned TickW   = $clog2(TickMax + 1);
    localparam int unsigned BeepW   = $clog2(ON_TICKS + OFF_TICKS + 1);

    localparam logic [PreW-1:0]  PreLast    = PreW'(TICK_DIV - 1);
    localparam logic [TickW-1:0] RingLast   = TickW'(RING_TIMEOUT - 1);
    localparam logic [TickW-1:0] SnoozeLast = TickW'(SNOOZE_TICKS - 1);
    localparam logic [BeepW-1:0] BeepLast   = BeepW'(ON_TICKS + OFF_TICKS - 1);
    localparam logic [BeepW-1:0] BeepOn     = BeepW'(ON_TICKS);
    localparam logic [3:0]       SnoozeMax  = 4'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StRinging = 2'b01,
        StSnooze  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [PreW-1:0]  pre_q, pre_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [BeepW-1:0] beep_q, beep_d;
    logic [3:0]       snz_q, snz_d;
    logic             missed_q, missed_d;
    logic             buzzer_q, buzzer_d;
    logic             match_q;
    logic             trigger, tick;

    always_comb begin
        trigger  = bus.time_match & ~match_q;
        tick     = (pre_q == PreLast);
        state_d  = state_q;
        snz_d    = snz_q;
        missed_d = missed_q;

        if (!bus.alarm_en) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (trigger) begin
                        state_d  = StRinging;
                        missed_d = 1'b0;
                        snz_d    = '0;
                    end else if (bus.stop_btn) begin
                        missed_d = 1'b0;
                    end
                end
                StRinging: begin
                    // An accepted snooze beats a coincident timeout; a refused one does not.
                    if (bus.stop_btn) begin
                        state_d = StIdle;
                    end else if (bus.snooze_btn && (snz_q < SnoozeMax)) begin
                        state_d = StSnooze;
                        snz_d   = snz_q + 4'd1;
                    end else if (tick && (tick_q == RingLast)) begin
                        state_d  = StIdle;
                        missed_d = 1'b1;
                    end
                end
                StSnooze: begin
                    if (bus.stop_btn) begin
                        state_d = StIdle;
                    end else if (tick && (tick_q == SnoozeLast)) begin
                        state_d = StRinging;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (state_d == StIdle) begin
            snz_d = '0;
        end

        // Timers restart on every state change so each duration is exact.
        pre_d  = '0;
        tick_d = '0;
        beep_d = '0;
        if ((state_d == state_q) && (state_q != StIdle)) begin
            if (tick) begin
                tick_d = tick_q + 1'b1;
                beep_d = (beep_q == BeepLast) ? '0 : beep_q + 1'b1;
            end else begin
                pre_d  = pre_q + 1'b1;
                tick_d = tick_q;
                beep_d = beep_q;
            end
        end

        buzzer_d = (state_d == StRinging) && (beep_d < BeepOn);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pre_q    <= '0;
            tick_q   <= '0;
            beep_q   <= '0;
            snz_q    <= '0;
            missed_q <= 1'b0;
            buzzer_q <= 1'b0;
            match_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            tick_q   <= tick_d;
            beep_q   <= beep_d;
            snz_q    <= snz_d;
            missed_q <= missed_d;
            buzzer_q <= buzzer_d;
            match_q  <= bus.time_match;
        end
    end

    assign bus.buzzer_en  = buzzer_q;
    assign bus.state      = state_q;
    assign bus.snooze_cnt = snz_q;
    assign bus.missed     = missed_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: constant vector table, directed
// multi-cycle sequences and random stimulus against a cycle-count reference model.
module tb_alarm_sequencer;

    localparam int TD    = 4;
    localparam int ON    = 2;
    localparam int OFF   = 1;
    localparam int RTO   = 10;
    localparam int SNZ   = 5;
    localparam int MAXS  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alarm_sequencer_if bus ();

    alarm_sequencer #(
        .TICK_DIV     (TD),
        .ON_TICKS     (ON),
        .OFF_TICKS    (OFF),
        .RING_TIMEOUT (RTO),
        .SNOOZE_TICKS (SNZ),
        .MAX_SNOOZE   (MAXS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: state name 0 idle / 1 ringing / 2 snooze, plus cycles since entry.
    int m_state, m_cyc, m_snz;
    logic m_missed, m_prev;

    function automatic logic [7:0] pack(input int st, input logic bz, input int sn, input logic ms);
        return {st[1:0], bz, sn[3:0], ms};
    endfunction

    function automatic logic [7:0] dut_out();
        return {bus.state, bus.buzzer_en, bus.snooze_cnt, bus.missed};
    endfunction

    function automatic logic [7:0] model_out();
        logic bz;
        bz = (m_state == 1) && (((m_cyc / TD) % (ON + OFF)) < ON);
        return pack(m_state, bz, m_snz, m_missed);
    endfunction

    task automatic model_reset();
        m_state = 0; m_cyc = 0; m_snz = 0; m_missed = 1'b0; m_prev = 1'b1;
    endtask

    task automatic model_step(input logic en, input logic tm, input logic sn, input logic sp);
        logic trig;
        int nxt;
        trig   = tm && !m_prev;
        m_prev = tm;
        nxt    = m_state;
        if (!en) nxt = 0;
        else if (m_state == 0) begin
            if (trig) begin nxt = 1; m_missed = 1'b0; m_snz = 0; end
            else if (sp) m_missed = 1'b0;
        end else if (m_state == 1) begin
            if (sp) nxt = 0;
            else if (sn && m_snz < MAXS) begin nxt = 2; m_snz++; end
            else if (m_cyc + 1 == RTO * TD) begin nxt = 0; m_missed = 1'b1; end
        end else begin
            if (sp) nxt = 0;
            else if (m_cyc + 1 == SNZ * TD) nxt = 1;
        end
        if (nxt == 0) m_snz = 0;
        m_cyc   = (nxt != m_state) ? 0 : m_cyc + 1;
        m_state = nxt;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got state=%b buzzer=%b snooze_cnt=%0d missed=%b, want state=%b buzzer=%b snooze_cnt=%0d missed=%b",
                      name, act[7:6], act[5], act[4:1], act[0], exp[7:6], exp[5], exp[4:1], exp[0]);
    endtask

    task automatic cycle(input logic en, input logic tm, input logic sn, input logic sp);
        bus.alarm_en   = en;
        bus.time_match = tm;
        bus.snooze_btn = sn;
        bus.stop_btn   = sp;
        @(posedge clk);
        model_step(en, tm, sn, sp);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic tm);
        rst_n = 1'b0;
        bus.alarm_en = 1'b1; bus.time_match = tm; bus.snooze_btn = 1'b0; bus.stop_btn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset", dut_out(), pack(0, 0, 0, 0));
    endtask

    typedef struct {
        logic en, tm, sn, sp;
        int st; logic bz; int sc; logic ms;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic tm;
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};

        do_reset(1'b0);
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].en, tbl[i].tm, tbl[i].sn, tbl[i].sp);
            check($sformatf("vec%0d", i), dut_out(), pack(tbl[i].st, tbl[i].bz, tbl[i].sc, tbl[i].ms));
        end

        // Full ring with no answer: 8 high / 4 low, timeout after 40 cycles.
        do_reset(1'b0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        check("t1_ring0", dut_out(), pack(1, 1, 0, 0));
        for (int k = 1; k < RTO * TD; k++) begin
            cycle(1, 1, 0, 0);
            check($sformatf("t1_ring%0d", k), dut_out(), pack(1, (k % 12) < 8, 0, 0));
        end
        cycle(1, 1, 0, 0);
        check("t1_timeout", dut_out(), pack(0, 0, 0, 1));

        // Snooze, re-ring after 20 cycles, then exhaust the snooze limit.
        do_reset(1'b0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        repeat (3) cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 0);
        check("t2_snooze", dut_out(), pack(2, 0, 1, 0));
        for (int k = 1; k < SNZ * TD; k++) begin
            cycle(1, 1, 0, 0);
            check($sformatf("t2_snz%0d", k), dut_out(), pack(2, 0, 1, 0));
        end
        cycle(1, 1, 0, 0);
        check("t2_rering", dut_out(), pack(1, 1, 1, 0));
        cycle(1, 1, 1, 0);
        check("t3_snooze2", dut_out(), pack(2, 0, 2, 0));
        repeat (SNZ * TD) cycle(1, 1, 0, 0);
        check("t3_rering2", dut_out(), pack(1, 1, 2, 0));
        cycle(1, 1, 1, 0);
        check("t3_snooze3_ignored", dut_out(), pack(1, 1, 2, 0));
        cycle(1, 1, 1, 1);
        check("t4_stop_wins", dut_out(), pack(0, 0, 0, 0));

        // Disable during snooze; held match must not retrigger.
        do_reset(1'b0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 0);
        check("t5_snooze", dut_out(), pack(2, 0, 1, 0));
        cycle(0, 1, 0, 0);
        check("t5_disable", dut_out(), pack(0, 0, 0, 0));
        repeat (5) cycle(1, 1, 0, 0);
        check("t5_no_retrig", dut_out(), pack(0, 0, 0, 0));
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        check("t5_retrig", dut_out(), pack(1, 1, 0, 0));

        // Match high across reset release, then async reset mid-ring.
        do_reset(1'b1);
        repeat (4) cycle(1, 1, 0, 0);
        check("t6_no_trig", dut_out(), pack(0, 0, 0, 0));
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        check("t6_ring", dut_out(), pack(1, 1, 0, 0));
        #2 rst_n = 1'b0;
        #1 check("t6_async", dut_out(), pack(0, 0, 0, 0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle(1, 1, 0, 0);
        check("t6_held", dut_out(), pack(0, 0, 0, 0));

        // Random stimulus against the reference model.
        do_reset(1'b0);
        tm = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic en, sn, sp;
            if ($urandom_range(0, 24) == 0) tm = ~tm;
            en = ($urandom_range(0, 99) != 0);
            sn = ($urandom_range(0, 11) == 0);
            sp = (i < 1500) ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 29) == 0);
            cycle(en, tm, sn, sp);
            check($sformatf("rand%0d", i), dut_out(), model_out());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
